// File: rtl/uart_rx_frontend_if.sv
// FIFO-side bundle of the UART receive front end: write port plus status flags.
interface uart_rx_frontend_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_write;
  logic                  o_frame_error;
  logic                  o_overrun;
  logic                  i_fifo_full;

  modport master (output o_data, o_write, o_frame_error, o_overrun, input i_fifo_full);
  modport slave  (input o_data, o_write, o_frame_error, o_overrun, output i_fifo_full);
endinterface

// File: rtl/uart_rx_frontend.sv
// UART receiver front end: 2-flop sync, start-bit validation, LSB-first sampling
// on a 16x oversampling tick, and one-cycle write/frame-error/overrun strobes.
module uart_rx_frontend #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_tick,
  input  logic                i_rx,
  uart_rx_frontend_if.master  rx_if
);

  localparam int TMAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] C_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_BIT  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_STOP = CW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] C_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                r_state,    w_state;
  logic [1:0]            r_sync;
  logic [CW-1:0]         r_tick_cnt, w_tick_cnt;
  logic [BW-1:0]         r_bit_cnt,  w_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift,    w_shift;
  logic [DATA_WIDTH-1:0] r_data,     w_data;
  logic                  r_write,    w_write;
  logic                  r_ferr,     w_ferr;
  logic                  r_ovr,      w_ovr;
  logic                  w_rx;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_sync <= 2'b11;
    else         r_sync <= {r_sync[0], i_rx};
  end

  assign w_rx = r_sync[1];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_write    <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tick_cnt <= w_tick_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_shift    <= w_shift;
      r_data     <= w_data;
      r_write    <= w_write;
      r_ferr     <= w_ferr;
      r_ovr      <= w_ovr;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_tick_cnt = r_tick_cnt;
    w_bit_cnt  = r_bit_cnt;
    w_shift    = r_shift;
    w_data     = r_data;
    w_write    = 1'b0;
    w_ferr     = 1'b0;
    w_ovr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) w_state = S_START;
      end
      S_START: begin
        if (i_tick) begin
          if (r_tick_cnt == C_MID) begin
            if (!w_rx) begin
              w_state   = S_DATA;
              w_bit_cnt = '0;
            end else begin
              w_state   = S_IDLE;
            end
          end else begin
            w_tick_cnt = r_tick_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (i_tick) begin
          if (r_tick_cnt == C_BIT) begin
            w_shift    = {w_rx, r_shift[DATA_WIDTH-1:1]};
            w_tick_cnt = '0;
            if (r_bit_cnt == C_LAST) begin
              w_state   = S_STOP;
              w_bit_cnt = '0;
            end else begin
              w_bit_cnt = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_cnt = r_tick_cnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (i_tick) begin
          if (r_tick_cnt == C_STOP) begin
            if (w_rx) begin
              w_state = S_IDLE;
              if (!rx_if.i_fifo_full) begin
                w_data  = r_shift;
                w_write = 1'b1;
              end else begin
                w_ovr   = 1'b1;
              end
            end else begin
              w_ferr  = 1'b1;
              w_state = S_BREAK;
            end
          end else begin
            w_tick_cnt = r_tick_cnt + 1'b1;
          end
        end
      end
      S_BREAK: begin
        // Held-low line must return high before another start can be seen.
        if (w_rx) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    if (w_state != r_state) w_tick_cnt = '0;
  end

  assign rx_if.o_data        = r_data;
  assign rx_if.o_write       = r_write;
  assign rx_if.o_frame_error = r_ferr;
  assign rx_if.o_overrun     = r_ovr;

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
Serial receiver stage that feeds the receive FIFO. Synchronises the raw RX line, detects and validates start bits, and samples DATA_WIDTH data bits (LSB first) plus one stop bit using a 16x oversampling tick from the shared baud-rate generator. Each good frame is presented as a parallel word with a single-cycle write strobe, wired straight to the FIFO write data and write enable. Framing and overrun conditions are flagged to the rest of the system.

Parameters:
DATA_WIDTH, 8, data bits per frame and width of o_data
OVERSAMPLE, 16, i_tick pulses per bit period
STOP_TICKS, 16, i_tick pulses spent in the stop bit before sampling it (16 = 1 stop bit)

Ports:
i_clock  input  1  system clock, 100 MHz
i_reset  input  1  asynchronous, active-high reset
i_tick  input  1  single-cycle oversampling strobe, OVERSAMPLE per bit period
i_rx  input  1  raw asynchronous serial line, idle high
i_fifo_full  input  1  receive FIFO full flag
o_data  output  DATA_WIDTH  last received word, connects to FIFO write data
o_write  output  1  one-cycle write strobe to the FIFO
o_frame_error  output  1  one-cycle pulse: stop bit sampled low
o_overrun  output  1  one-cycle pulse: good frame dropped because FIFO full

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Both synchroniser flops reset to 1, state IDLE, tick counter 0, bit counter 0, shift register 0, o_data 0, o_write 0, o_frame_error 0, o_overrun 0.
- Synchroniser: two flops on i_rx. All logic uses the second flop (rx_s). Adds 2 clocks of latency.
- Counters: tick counter counts i_tick pulses only. It is wide enough for max(OVERSAMPLE, STOP_TICKS) and is cleared on every state change. Bit counter runs 0..DATA_WIDTH-1.
- States:
  - IDLE: when rx_s == 0, go to START and clear the tick counter. i_tick is not required.
  - START: on the tick at which the counter reaches OVERSAMPLE/2-1 (mid-bit), sample rx_s. If 0, go to DATA and clear both counters. If 1, treat as a glitch and return to IDLE; no flags are raised.
  - DATA: on the tick at which the counter reaches OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift, so bits arrive LSB first) and clear the tick counter. After the shift of bit DATA_WIDTH-1, go to STOP.
  - STOP: on the tick at which the counter reaches STOP_TICKS-1, sample rx_s.
    - If 1 and i_fifo_full == 0: load o_data with the shift register, pulse o_write, go to IDLE.
    - If 1 and i_fifo_full == 1: leave o_data unchanged, no o_write, pulse o_overrun, go to IDLE.
    - If 0: leave o_data unchanged, no o_write, pulse o_frame_error, go to BREAK_WAIT.
  - BREAK_WAIT: stay until rx_s == 1, then go to IDLE. This prevents a held-low line (break) from producing repeated frames.
- o_write, o_frame_error and o_overrun are registered. Each is high for exactly one clock, the clock after the edge on which the stop bit is sampled. At most one of the three is high in any cycle.
- o_data stays stable between writes. It is valid whenever o_write is high.
- i_fifo_full is sampled only at the stop-bit decision. A FIFO that becomes full mid-frame does not affect reception.
- Back-to-back frames: a start bit that follows immediately after the stop-sample tick is accepted. The next frame is detected in the IDLE cycle that follows.
- Reset mid-frame: the frame is discarded, no strobe is emitted, and the block returns to IDLE.
- i_tick held high continuously is legal; it simply counts every clock.

Test Plan:
- Tick every 4 clocks; send 0x55 (8N1) -> exactly one o_write pulse with o_data = 0x55; no error flags.
- Send 0xA3 then 0x0F with no idle gap between frames -> two o_write pulses in order, carrying 0xA3 then 0x0F.
- Drive i_rx low for 4 ticks only, then high -> state returns to IDLE; no o_write, o_frame_error or o_overrun.
- Send 0xFF with stop bit driven low, then hold i_rx low for 40 ticks, then release -> a single o_frame_error pulse, no o_write, o_data keeps its prior value; after release, 0x3C is received correctly.
- i_fifo_full = 1 while sending 0x81 -> one o_overrun pulse, no o_write. Then i_fifo_full = 0 and send 0x7E -> o_write with o_data = 0x7E.
- Assert i_reset during bit 3 of 0xC6, then release -> all outputs 0, no strobe. A following 0x12 is received correctly.
